// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the two-port 16-bit SRAM arbiter.
// Latency: n/a (types, constants and a pure address helper only).
// Backpressure: n/a.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    GNT_P = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int unsigned DEF_WAIT      = 2;

  // Word index inside the SRAM: the offset from the base wraps at 32 bits,
  // the byte lane bits are dropped and everything above bit 18 is discarded.
  function automatic logic [16:0] sram_word_idx(input logic [31:0] addr,
                                                input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return off[18:2];
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle: pipeline port P and debug/loader port D.
// Latency: n/a (wiring only).
// Backpressure: P stalls on p_not_ready; D holds d_req until the d_ack pulse.
//   slave  : seen by the arbiter (requests in, responses out)
//   master : seen by the requesters
interface sram_arbiter_if;
  logic        p_rd;
  logic        p_wr;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_not_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  modport slave (
    input  p_rd, p_wr, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata,
    output p_rdata, p_not_ready, d_rdata, d_ack
  );

  modport master (
    output p_rd, p_wr, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata,
    input  p_rdata, p_not_ready, d_rdata, d_ack
  );
endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter holding the last granted side.
// Latency: grant is combinational from req_*/en; last grant updates next edge.
// Backpressure: no grant while en is low; the losing side simply stays pending.
//   clk, rst        : clock, synchronous active-high reset (last grant -> D)
//   req_p, req_d    : requests from the pipeline and debug sides
//   en              : arbitration window (the owner FSM is idle)
//   gnt_p, gnt_d    : one-hot grant, valid only while en is high
module sram_rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_p,
  input  logic req_d,
  input  logic en,
  output logic gnt_p,
  output logic gnt_d
);

  gnt_e last_q, last_d;

  always_comb begin
    gnt_p  = 1'b0;
    gnt_d  = 1'b0;
    last_d = last_q;
    if (en) begin
      if (req_p && req_d) begin
        // On contention the side that did not win last time goes first.
        gnt_p = (last_q == GNT_D);
        gnt_d = (last_q == GNT_P);
      end else begin
        gnt_p = req_p;
        gnt_d = req_d;
      end
    end
    if (gnt_p) begin
      last_d = GNT_P;
    end else if (gnt_d) begin
      last_d = GNT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares a 16-bit external SRAM between the pipeline (P) and a debug port (D);
//   each 32-bit access is two halfword phases of WAIT cycles plus a DONE cycle.
// Latency: 2*WAIT+1 cycles of stall for an uncontended P access, then 1 idle cycle.
// Backpressure: P sees p_not_ready until its DONE cycle; D waits for d_ack.
//   clk, rst     : clock, synchronous active-high reset (aborts any access)
//   bus          : P/D request/response bundle (slave side)
//   SRAMaddress  : halfword address {word index, half}
//   SRAMWEn/OE   : active-low write and output enables
//   SRAMdata     : bidirectional data, driven only during write phases
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned WAIT      = DEF_WAIT
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus,
  output logic [17:0]   SRAMaddress,
  output logic          SRAMWEn,
  output logic          SRAMOE,
  inout  wire  [15:0]   SRAMdata
);

  localparam int unsigned    CW   = $clog2(WAIT);
  localparam logic [CW-1:0]  LAST = CW'(WAIT - 1);

  state_e        state_q, state_d;
  gnt_e          grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          half_q, half_d;
  logic [16:0]   idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic p_req;
  logic arb_gnt_p, arb_gnt_d;
  logic access;
  logic cnt_last;

  assign p_req    = bus.p_rd | bus.p_wr;
  assign access   = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign cnt_last = (cnt_q == LAST);

  sram_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_p (p_req),
    .req_d (bus.d_req),
    .en    (state_q == ST_IDLE),
    .gnt_p (arb_gnt_p),
    .gnt_d (arb_gnt_d)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    half_d  = half_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt_p || arb_gnt_d) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          half_d  = 1'b0;
          if (arb_gnt_p) begin
            grant_d = GNT_P;
            we_d    = bus.p_wr;  // p_rd together with p_wr is a write
            idx_d   = sram_word_idx(bus.p_addr, 32'(BASE_ADDR));
            wdata_d = bus.p_wdata;
          end else begin
            grant_d = GNT_D;
            we_d    = bus.d_we;
            idx_d   = sram_word_idx(bus.d_addr, 32'(BASE_ADDR));
            wdata_d = bus.d_wdata;
          end
        end
      end
      ST_LOW: begin
        if (cnt_last) begin
          if (!we_q) rdata_d[15:0] = SRAMdata;
          state_d = ST_HIGH;
          cnt_d   = '0;
          half_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_last) begin
          if (!we_q) rdata_d[31:16] = SRAMdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_D;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      half_q  <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      half_q  <= half_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Address and half stay registered after an access, so the bus holds still.
  assign SRAMaddress = {idx_q, half_q};
  assign SRAMOE      = !(access && !we_q);
  // The first cycle of each half is address setup with the write strobe off.
  assign SRAMWEn     = !(access && we_q && (cnt_q != '0));
  assign SRAMdata    = (access && we_q) ? (half_q ? wdata_q[31:16] : wdata_q[15:0])
                                        : 16'hzzzz;

  assign bus.p_rdata     = rdata_q;
  assign bus.d_rdata     = rdata_q;
  assign bus.p_not_ready = p_req && !(state_q == ST_DONE && grant_q == GNT_P);
  assign bus.d_ack       = (state_q == ST_DONE) && (grant_q == GNT_D);

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int          W     = 2;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          T_ONE = 2 * W + 1;      // cycle index of first DONE
  localparam int          T_TWO = 2 * T_ONE + 1;  // DONE of the queued access
  localparam int          NCYC  = 30;

  logic clk = 1'b0;
  logic rst;
  sram_arbiter_if bus ();
  logic [17:0] sram_addr;
  logic        sram_wen;
  logic        sram_oe;
  wire  [15:0] sram_data;

  sram_arbiter #(.BASE_ADDR(1024), .WAIT(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .SRAMaddress (sram_addr),
    .SRAMWEn     (sram_wen),
    .SRAMOE      (sram_oe),
    .SRAMdata    (sram_data)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM chip.
  logic [15:0] sram_mem [0:262143];
  always @(posedge clk) if (!sram_wen) sram_mem[sram_addr] <= sram_data;
  assign sram_data = (!sram_oe && sram_wen) ? sram_mem[sram_addr] : 16'hzzzz;

  // Reference model: word-addressed memory plus who won last.
  logic [31:0] ref_mem [bit [16:0]];
  gnt_e        model_last;
  int          checks   = 0;
  int          failures = 0;

  logic        oe_hist   [NCYC];
  logic        wen_hist  [NCYC];
  logic        nr_hist   [NCYC];
  logic [17:0] addr_hist [NCYC];

  function automatic logic [16:0] model_idx(input logic [31:0] addr);
    return 17'((addr - BASE) / 4);
  endfunction

  // Drives at most one P and one D request (D after d_delay cycles) for NCYC
  // cycles, dropping each request when it completes. Called at a negedge.
  task automatic run_pair(input bit pr, input bit pw, input logic [31:0] pa,
                          input logic [31:0] pd, input bit de, input bit dw,
                          input logic [31:0] da, input logic [31:0] dd,
                          input int d_delay, output int p_done, output int d_done,
                          output int d_acks, output logic [31:0] p_obs,
                          output logic [31:0] d_obs);
    bit p_act, d_act;
    p_done = -1; d_done = -1; d_acks = 0; p_obs = '0; d_obs = '0;
    p_act = 1'b0; d_act = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      if ((pr || pw) && c == 0) begin
        bus.p_rd = pr; bus.p_wr = pw; bus.p_addr = pa; bus.p_wdata = pd;
        p_act = 1'b1;
      end
      if (de && c == d_delay) begin
        bus.d_req = 1'b1; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
        d_act = 1'b1;
      end
      #1;
      oe_hist[c] = sram_oe; wen_hist[c] = sram_wen;
      nr_hist[c] = bus.p_not_ready; addr_hist[c] = sram_addr;
      if (p_act && !bus.p_not_ready) begin
        p_done = c; p_obs = bus.p_rdata; p_act = 1'b0;
        bus.p_rd = 1'b0; bus.p_wr = 1'b0;
      end
      if (bus.d_ack) begin
        d_acks++;
        if (d_act) begin
          d_done = c; d_obs = bus.d_rdata; d_act = 1'b0; bus.d_req = 1'b0;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.p_rd = 0; bus.p_wr = 0; bus.p_addr = 0; bus.p_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (3) @(negedge clk);
    checks++; if (sram_wen !== 1'b1) begin failures++; $display("FAIL reset_wen got=%b exp=1", sram_wen); end
    checks++; if (sram_oe !== 1'b1) begin failures++; $display("FAIL reset_oe got=%b exp=1", sram_oe); end
    checks++; if (sram_addr !== 18'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
    checks++; if (bus.p_rdata !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", bus.p_rdata); end
    checks++; if (bus.d_rdata !== 32'h0) begin failures++; $display("FAIL reset_drdata got=%h exp=0", bus.d_rdata); end
    checks++; if (bus.d_ack !== 1'b0) begin failures++; $display("FAIL reset_dack got=%b exp=0", bus.d_ack); end
    rst = 1'b0;
    model_last = GNT_D;
    @(negedge clk);
  endtask

  task automatic test_store();
    int pdn, ddn, acks, nr, wl, ol;
    logic [31:0] po, dob;
    run_pair(0, 1, 32'd1028, 32'hDEADBEEF, 0, 0, 0, 0, 0, pdn, ddn, acks, po, dob);
    ref_mem[model_idx(32'd1028)] = 32'hDEADBEEF;
    model_last = GNT_P;
    nr = 0; wl = 0; ol = 0;
    for (int c = 0; c < NCYC; c++) begin
      nr += int'(nr_hist[c]); wl += int'(!wen_hist[c]); ol += int'(!oe_hist[c]);
    end
    checks++; if (pdn != T_ONE) begin failures++; $display("FAIL store_done got=%0d exp=%0d", pdn, T_ONE); end
    checks++; if (nr != T_ONE) begin failures++; $display("FAIL store_stall got=%0d exp=%0d", nr, T_ONE); end
    checks++; if (sram_mem[2] !== 16'hBEEF) begin failures++; $display("FAIL store_lo got=%h exp=beef", sram_mem[2]); end
    checks++; if (sram_mem[3] !== 16'hDEAD) begin failures++; $display("FAIL store_hi got=%h exp=dead", sram_mem[3]); end
    checks++; if (wl != 2 * (W - 1)) begin failures++; $display("FAIL store_wen_cycles got=%0d exp=%0d", wl, 2 * (W - 1)); end
    checks++; if (ol != 0) begin failures++; $display("FAIL store_oe_cycles got=%0d exp=0", ol); end
  endtask

  task automatic test_load();
    int pdn, ddn, acks, wl, ol;
    logic [31:0] po, dob;
    logic [16:0] i;
    i = model_idx(32'd1028);
    run_pair(1, 0, 32'd1028, 0, 0, 0, 0, 0, 0, pdn, ddn, acks, po, dob);
    model_last = GNT_P;
    wl = 0; ol = 0;
    for (int c = 0; c < NCYC; c++) begin
      wl += int'(!wen_hist[c]); ol += int'(!oe_hist[c]);
    end
    checks++; if (po !== ref_mem[i]) begin failures++; $display("FAIL load_data got=%h exp=%h", po, ref_mem[i]); end
    checks++; if (pdn != T_ONE) begin failures++; $display("FAIL load_done got=%0d exp=%0d", pdn, T_ONE); end
    checks++; if (ol != 2 * W) begin failures++; $display("FAIL load_oe_cycles got=%0d exp=%0d", ol, 2 * W); end
    checks++; if (wl != 0) begin failures++; $display("FAIL load_wen_cycles got=%0d exp=0", wl); end
    checks++; if (addr_hist[1] !== {i, 1'b0}) begin failures++; $display("FAIL load_addr_lo got=%h exp=%h", addr_hist[1], {i, 1'b0}); end
    checks++; if (addr_hist[1 + W] !== {i, 1'b1}) begin failures++; $display("FAIL load_addr_hi got=%h exp=%h", addr_hist[1 + W], {i, 1'b1}); end
  endtask

  task automatic test_contention();
    int pdn, ddn, acks, exp_p, exp_d;
    logic [31:0] po, dob, pd, dd;
    bit p_first;
    for (int r = 0; r < 2; r++) begin
      pd = $urandom; dd = $urandom;
      p_first = (model_last == GNT_D);
      exp_p = p_first ? T_ONE : T_TWO;
      exp_d = p_first ? T_TWO : T_ONE;
      run_pair(0, 1, 32'd1032, pd, 1, 1, 32'd1036, dd, 0, pdn, ddn, acks, po, dob);
      model_last = p_first ? GNT_D : GNT_P;
      ref_mem[model_idx(32'd1032)] = pd;
      ref_mem[model_idx(32'd1036)] = dd;
      checks++; if (pdn != exp_p) begin failures++; $display("FAIL contend%0d_p_done got=%0d exp=%0d", r, pdn, exp_p); end
      checks++; if (ddn != exp_d) begin failures++; $display("FAIL contend%0d_d_done got=%0d exp=%0d", r, ddn, exp_d); end
      checks++; if (acks != 1) begin failures++; $display("FAIL contend%0d_acks got=%0d exp=1", r, acks); end
      checks++; if ({sram_mem[5], sram_mem[4]} !== pd) begin failures++; $display("FAIL contend%0d_pmem got=%h exp=%h", r, {sram_mem[5], sram_mem[4]}, pd); end
      checks++; if ({sram_mem[7], sram_mem[6]} !== dd) begin failures++; $display("FAIL contend%0d_dmem got=%h exp=%h", r, {sram_mem[7], sram_mem[6]}, dd); end
    end
  endtask

  task automatic test_d_during_p();
    int pdn, ddn, acks;
    logic [31:0] po, dob, dd;
    dd = $urandom;
    run_pair(1, 0, 32'd1028, 0, 1, 1, 32'd1040, dd, 2, pdn, ddn, acks, po, dob);
    model_last = GNT_D;
    ref_mem[model_idx(32'd1040)] = dd;
    checks++; if (pdn != T_ONE) begin failures++; $display("FAIL dmid_p_done got=%0d exp=%0d", pdn, T_ONE); end
    checks++; if (ddn != T_TWO) begin failures++; $display("FAIL dmid_d_done got=%0d exp=%0d", ddn, T_TWO); end
    checks++; if (po !== ref_mem[model_idx(32'd1028)]) begin failures++; $display("FAIL dmid_p_data got=%h exp=%h", po, ref_mem[model_idx(32'd1028)]); end
    checks++; if ({sram_mem[9], sram_mem[8]} !== dd) begin failures++; $display("FAIL dmid_dmem got=%h exp=%h", {sram_mem[9], sram_mem[8]}, dd); end
  endtask

  task automatic test_reset_mid();
    bus.p_wr = 1'b1; bus.p_addr = 32'd1060; bus.p_wdata = 32'h12345678;
    repeat (1 + W) @(negedge clk);  // now in the first HIGH cycle
    checks++; if (sram_addr[0] !== 1'b1) begin failures++; $display("FAIL rstmid_in_high got=%b exp=1", sram_addr[0]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sram_wen !== 1'b1) begin failures++; $display("FAIL rstmid_wen got=%b exp=1", sram_wen); end
    checks++; if (sram_oe !== 1'b1) begin failures++; $display("FAIL rstmid_oe got=%b exp=1", sram_oe); end
    checks++; if (bus.d_ack !== 1'b0) begin failures++; $display("FAIL rstmid_dack got=%b exp=0", bus.d_ack); end
    checks++; if (sram_addr !== 18'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", sram_addr); end
    checks++; if (bus.p_not_ready !== 1'b1) begin failures++; $display("FAIL rstmid_stall got=%b exp=1", bus.p_not_ready); end
    rst = 1'b0; bus.p_wr = 1'b0;
    model_last = GNT_D;
    @(negedge clk);
  endtask

  task automatic test_addr_map();
    logic [31:0] addrs [3];
    int pdn, ddn, acks;
    logic [31:0] po, dob;
    logic [16:0] i;
    addrs[0] = 32'd1024 + 32'd4 * 32'd32767;
    addrs[1] = 32'd1024 + 32'd4 * 32'd131071 + 32'd3;
    addrs[2] = 32'd1020;
    for (int k = 0; k < 3; k++) begin
      i = model_idx(addrs[k]);
      run_pair(1, 0, addrs[k], 0, 0, 0, 0, 0, 0, pdn, ddn, acks, po, dob);
      model_last = GNT_P;
      checks++; if (addr_hist[1] !== {i, 1'b0}) begin failures++; $display("FAIL map%0d_lo got=%h exp=%h", k, addr_hist[1], {i, 1'b0}); end
      checks++; if (addr_hist[1 + W] !== {i, 1'b1}) begin failures++; $display("FAIL map%0d_hi got=%h exp=%h", k, addr_hist[1 + W], {i, 1'b1}); end
    end
  endtask

  task automatic test_random();
    int pdn, ddn, acks, exp_p, exp_d;
    logic [31:0] po, dob, pa, da, pd, dd, exp_po, exp_do;
    bit pe, de, pr, pw, dw, p_first, is_p;
    int mask;
    for (int r = 0; r < 24; r++) begin
      mask = $urandom_range(1, 3);
      pe = mask[0]; de = mask[1];
      pa = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      da = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      pd = $urandom; dd = $urandom;
      pw = 1'($urandom_range(0, 1)); dw = 1'($urandom_range(0, 1));
      if (!ref_mem.exists(model_idx(pa))) pw = 1'b1;
      if (!ref_mem.exists(model_idx(da))) dw = 1'b1;
      pr = pw ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!pe) begin pr = 1'b0; pw = 1'b0; end
      p_first = (pe && de) ? (model_last == GNT_D) : pe;
      exp_p = p_first ? T_ONE : T_TWO;
      exp_d = (pe && p_first) ? T_TWO : T_ONE;
      exp_po = '0; exp_do = '0;
      for (int k = 0; k < 2; k++) begin
        is_p = (k == 0) ? p_first : !p_first;
        if (is_p && pe) begin
          if (pw) ref_mem[model_idx(pa)] = pd; else exp_po = ref_mem[model_idx(pa)];
        end else if (!is_p && de) begin
          if (dw) ref_mem[model_idx(da)] = dd; else exp_do = ref_mem[model_idx(da)];
        end
      end
      if (pe && de) model_last = p_first ? GNT_D : GNT_P;
      else          model_last = pe ? GNT_P : GNT_D;
      run_pair(pr, pw, pa, pd, de, dw, da, dd, 0, pdn, ddn, acks, po, dob);
      if (pe) begin
        checks++; if (pdn != exp_p) begin failures++; $display("FAIL rnd%0d_p_done got=%0d exp=%0d", r, pdn, exp_p); end
        if (!pw) begin
          checks++; if (po !== exp_po) begin failures++; $display("FAIL rnd%0d_p_data got=%h exp=%h", r, po, exp_po); end
        end
      end
      if (de) begin
        checks++; if (ddn != exp_d) begin failures++; $display("FAIL rnd%0d_d_done got=%0d exp=%0d", r, ddn, exp_d); end
        if (!dw) begin
          checks++; if (dob !== exp_do) begin failures++; $display("FAIL rnd%0d_d_data got=%h exp=%h", r, dob, exp_do); end
        end
      end
      checks++; if (acks != int'(de)) begin failures++; $display("FAIL rnd%0d_acks got=%0d exp=%0d", r, acks, int'(de)); end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_contention();
    test_d_during_p();
    test_reset_mid();
    test_addr_map();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
